med_frame_writer: RTL

//  Sink end of the median-filter pixel stream. Captures filtered pixels (one 8-bit

---
 rtl/med_frame_writer_pkg.sv | 16 +
 rtl/med_frame_writer_skid.sv | 57 +++++
 rtl/med_frame_writer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/med_frame_writer_pkg.sv
// Shared frame geometry and writer state encoding for the median-filter pipeline.
// med_filter imports the same constants so producer and sink agree on frame size.
package med_pkg;
  localparam int IMG_W     = 222;
  localparam int IMG_H     = 222;
  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int DW        = 8;
  localparam int AW        = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2,
    REPLAY  = 2'd3
  } state_t;
endpackage

// File: rtl/med_frame_writer_skid.sv
// Two-entry skid buffer turning a 1-cycle-latency BRAM read into a valid/ready stream.
// A read is granted only if its data is guaranteed a free slot when it returns.
module med_rd_skid #(
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          req_i,
  input  logic          req_last_i,
  output logic          grant_o,
  input  logic [DW-1:0] ram_dout_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_last_o
);
  logic [DW-1:0] data_q [2];
  logic [1:0]    last_q;
  logic          rd_ptr_q, wr_ptr_q;
  logic [1:0]    cnt_q, cnt_after;
  logic          inflight_q, inflight_last_q;
  logic          push, pop;

  // Stream: a beat transfers on out_valid_o & out_ready_i; head entry is held
  // unchanged (entries never shift) while out_valid_o & !out_ready_i.
  assign out_valid_o = (cnt_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  assign push        = inflight_q;
  assign cnt_after   = cnt_q + {1'b0, push} - {1'b0, pop};
  assign grant_o     = req_i & (cnt_after <= 2'd1);
  assign out_data_o  = out_valid_o ? data_q[rd_ptr_q] : '0;
  assign out_last_o  = out_valid_o & last_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      cnt_q           <= 2'd0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= grant_o;
      inflight_last_q <= req_last_i;
      cnt_q           <= cnt_after;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q] <= ram_dout_i;
      last_q[wr_ptr_q] <= inflight_last_q;
    end
  end
endmodule

// File: rtl/med_frame_writer.sv
// Captures one filtered frame into an external single-port BRAM in raster order,
// then replays it on demand as a valid/ready stream; dbg_state exposes the FSM.
module med_frame_writer #(
  parameter int IMG_W = med_pkg::IMG_W,
  parameter int IMG_H = med_pkg::IMG_H,
  parameter int DW    = med_pkg::DW,
  parameter int AW    = med_pkg::AW
) (
  input  logic          clk_75,
  input  logic          rst,
  input  logic          start,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  input  logic          rd_start,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          finished,
  output logic          overflow,
  output logic [1:0]    dbg_state
);
  import med_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_W * IMG_H - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d, rd_addr_q, rd_addr_d;
  logic          all_issued_q, all_issued_d, overflow_q, overflow_d;
  logic          wr_en, wr_last, rd_req, rd_grant, rd_fire;

  // start overrides every state, so a pixel arriving with it lands at address 0.
  assign wr_en   = !rst && pix_valid && (start || state_q == CAPTURE);
  assign wr_last = !start && state_q == CAPTURE && pix_valid && wr_cnt_q == LAST_ADDR;
  assign rd_req  = !rst && !start &&
                   ((state_q == DONE && rd_start) || (state_q == REPLAY && !all_issued_q));
  assign rd_fire = rd_valid && rd_ready && rd_last;

  always_ff @(posedge clk_75) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start) state_d = CAPTURE;
    else begin
      case (state_q)
        CAPTURE: if (wr_last)  state_d = DONE;
        DONE:    if (rd_start) state_d = REPLAY;
        REPLAY:  if (rd_fire)  state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    ram_we    = wr_en;
    ram_addr  = '0;
    ram_din   = '0;
    if (wr_en) begin
      ram_addr = start ? '0 : wr_cnt_q;
      ram_din  = pix_data;
    end else if (rd_grant) begin
      ram_addr = rd_addr_q;
    end
    busy      = (state_q == CAPTURE) || (state_q == REPLAY);
    finished  = (state_q == DONE) || (state_q == REPLAY);
    overflow  = overflow_q;
    dbg_state = state_q;
  end

  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    rd_addr_d    = rd_addr_q;
    all_issued_d = all_issued_q;
    overflow_d   = overflow_q;
    if (start) begin
      wr_cnt_d     = pix_valid ? AW'(1) : '0;
      rd_addr_d    = '0;
      all_issued_d = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      if (state_q == CAPTURE && pix_valid && wr_cnt_q != LAST_ADDR)
        wr_cnt_d = wr_cnt_q + AW'(1);
      if ((state_q == DONE || state_q == REPLAY) && pix_valid)
        overflow_d = 1'b1;
      // Each address is issued exactly once per replay; all_issued stops the counter.
      if (rd_grant) begin
        if (rd_addr_q == LAST_ADDR) all_issued_d = 1'b1;
        else                        rd_addr_d    = rd_addr_q + AW'(1);
      end
      if (state_q == REPLAY && rd_fire) begin
        rd_addr_d    = '0;
        all_issued_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_75) begin
    if (rst) begin
      wr_cnt_q     <= '0;
      rd_addr_q    <= '0;
      all_issued_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      rd_addr_q    <= rd_addr_d;
      all_issued_q <= all_issued_d;
      overflow_q   <= overflow_d;
    end
  end

  med_rd_skid #(.DW(DW)) u_skid (
    .clk_i       (clk_75),
    .rst_i       (rst),
    .flush_i     (start),
    .req_i       (rd_req),
    .req_last_i  (rd_addr_q == LAST_ADDR),
    .grant_o     (rd_grant),
    .ram_dout_i  (ram_dout),
    .out_valid_o (rd_valid),
    .out_ready_i (rd_ready),
    .out_data_o  (rd_data),
    .out_last_o  (rd_last)
  );
endmodule
